linear_trans_spn_iter: RTL and testbench



---
 rtl/linear_trans_spn_pkg.sv | 23 ++
 rtl/linear_trans_spn_iter_if.sv | 24 ++
 rtl/linear_trans_spn_core.sv | 35 +++
 rtl/linear_trans_spn_iter.sv | 72 +++++++
 tb/tb_linear_trans_spn_iter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/linear_trans_spn_pkg.sv
// rtl/linear_trans_spn_pkg.sv - shared types, constants and GF(2^W) helper for the iterative SPN linear layer
package linear_trans_spn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam int NLANES = 4;
    localparam int MAXW   = 64;

    // Multiply by x in GF(2^w); operands are carried in MAXW-bit containers, upper bits ignored.
    function automatic logic [MAXW-1:0] xtime(input logic [MAXW-1:0] x,
                                              input logic [MAXW-1:0] poly,
                                              input int              w);
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] r;
        mask = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
        r    = (x << 1) & mask;
        if (x[w-1]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/linear_trans_spn_iter_if.sv
// rtl/linear_trans_spn_iter_if.sv - input/output handshake bundle for the iterative linear layer
interface linear_trans_spn_iter_if #(
    parameter int W  = 32,
    parameter int IW = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [4*W-1:0]   in_data;
    logic [IW-1:0]    in_iter;
    logic             out_valid;
    logic             out_ready;
    logic [4*W-1:0]   out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_iter, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_iter, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/linear_trans_spn_core.sv
// rtl/linear_trans_spn_core.sv - one combinational application of the four-lane diffusion matrix
module linear_trans_spn_core
    import linear_trans_spn_pkg::*;
#(
    parameter int             W    = 32,
    parameter logic [W-1:0]   POLY = W'(32'h0000_008D)
) (
    input  logic [NLANES*W-1:0] a_i,
    output logic [NLANES*W-1:0] b_o
);

    function automatic logic [W-1:0] x2(input logic [W-1:0] v);
        return W'(xtime(MAXW'(v), MAXW'(POLY), W));
    endfunction

    logic [W-1:0] a0, a1, a2, a3;
    logic [W-1:0] t13, t02, u23, u01;

    assign a0 = a_i[0*W +: W];
    assign a1 = a_i[1*W +: W];
    assign a2 = a_i[2*W +: W];
    assign a3 = a_i[3*W +: W];

    // Four shared products cover all sixteen matrix terms.
    assign t13 = x2(a1 ^ a3);
    assign t02 = x2(a0 ^ a2);
    assign u23 = x2(x2(a2 ^ a3));
    assign u01 = x2(x2(a0 ^ a1));

    assign b_o[0*W +: W] = a0 ^ t13 ^ u23;
    assign b_o[1*W +: W] = a1 ^ t02 ^ u23;
    assign b_o[2*W +: W] = a2 ^ t13 ^ u01;
    assign b_o[3*W +: W] = a3 ^ t02 ^ u01;

endmodule

// File: rtl/linear_trans_spn_iter.sv
// rtl/linear_trans_spn_iter.sv - applies the diffusion matrix a programmable number of times, one per clock
module linear_trans_spn_iter
    import linear_trans_spn_pkg::*;
#(
    parameter int             W    = 32,
    parameter logic [W-1:0]   POLY = W'(32'h0000_008D),
    parameter int             IW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    linear_trans_spn_iter_if.slave   bus
);

    fsm_e                   fsm_q, fsm_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic [NLANES*W-1:0]    data_q, data_d;
    logic [NLANES*W-1:0]    m_out;

    linear_trans_spn_core #(.W(W), .POLY(POLY)) u_core (
        .a_i (data_q),
        .b_o (m_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d = bus.in_data;
                    cnt_d  = bus.in_iter;
                    fsm_d  = (bus.in_iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // RUN is only entered with cnt >= 1, so the counter stops at 0 and never wraps.
                data_d = m_out;
                cnt_d  = cnt_q - IW'(1);
                if (cnt_q == IW'(1)) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (fsm_q == IDLE) && !rst;
        bus.out_valid = (fsm_q == DONE);
        bus.busy      = (fsm_q != IDLE);
        bus.out_data  = data_q;
    end

endmodule

// File: tb/tb_linear_trans_spn_iter.sv
// tb/tb_linear_trans_spn_iter.sv - scoreboard bench for the iterative SPN linear layer
module tb_linear_trans_spn_iter;

    typedef struct {
        logic [127:0] d;
        int           n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   seen = 1'b0;
    exp_t q[$];

    localparam logic [127:0] V_A0   = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] R_A0   = 128'h00000006_00000004_00000002_00000001;
    localparam logic [127:0] V_RED  = 128'h00000000_00000000_80000000_00000000;
    localparam logic [127:0] R_RED  = 128'h0000011A_00000197_80000000_0000008D;

    linear_trans_spn_iter_if #(.W(32), .IW(4)) bus ();

    linear_trans_spn_iter #(.W(32), .POLY(32'h0000_008D), .IW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising out_valid, data on each completed output handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else begin
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 128'(bus.out_valid), 128'(0));
                end else if (q[0].n == 0) begin
                    chk("latency_n0", 128'((cyc - acc_cyc) <= 1), 128'(1));
                end else begin
                    chk("latency", 128'(cyc - acc_cyc), 128'(q[0].n));
                end
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", bus.out_data, e.d);
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [3:0] n,
                        input logic [127:0] exp, input bit expect_out);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_iter  = n;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", 128'(bus.in_ready), 128'(1));
        if (expect_out) begin
            e.d = exp;
            e.n = int'(n);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_iter  = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 128'(q.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] rnd;
        int           t;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_iter   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_out_data", bus.out_data, 128'(0));

        send(V_A0, 4'd1, R_A0, 1'b1);
        drain();
        send(V_RED, 4'd1, R_RED, 1'b1);
        drain();
        send(V_A0, 4'd2, V_A0, 1'b1);
        drain();
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(rnd, 4'd2, rnd, 1'b1);
        drain();
        send(R_RED, 4'd0, R_RED, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        send(V_A0, 4'd1, R_A0, 1'b1);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_out_data", bus.out_data, R_A0);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_in_ready", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        chk("bp_after_in_ready", 128'(bus.in_ready), 128'(1));
        chk("bp_after_out_valid", 128'(bus.out_valid), 128'(0));
        drain();

        send(V_A0, 4'd15, R_A0, 1'b1);
        drain();

        send(V_RED, 4'd10, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
        send(V_A0, 4'd1, R_A0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
